// File: rtl/cfu_pkg.sv
// Shared types and constants for the condition/flag unit: ARM condition codes,
// NZCV bit positions and the ALU decoder flag-write encoding.
package cfu_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondCs = 4'b0010,
    CondCc = 4'b0011,
    CondMi = 4'b0100,
    CondPl = 4'b0101,
    CondVs = 4'b0110,
    CondVc = 4'b0111,
    CondHi = 4'b1000,
    CondLs = 4'b1001,
    CondGe = 4'b1010,
    CondLt = 4'b1011,
    CondGt = 4'b1100,
    CondLe = 4'b1101,
    CondAl = 4'b1110,
    CondNv = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // [1] writes N,Z; [0] writes C,V
  typedef logic [1:0] flagw_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation of a 4-bit condition field against
// the stored NZCV flags.
module cond_check
  import cfu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b1;
    unique case (cond_e'(cond_i))
      CondEq: pass_o = z;
      CondNe: pass_o = ~z;
      CondCs: pass_o = c;
      CondCc: pass_o = ~c;
      CondMi: pass_o = n;
      CondPl: pass_o = ~n;
      CondVs: pass_o = v;
      CondVc: pass_o = ~v;
      CondHi: pass_o = c & ~z;
      CondLs: pass_o = ~c | z;
      CondGe: pass_o = (n == v);
      CondLt: pass_o = (n != v);
      CondGt: pass_o = ~z & (n == v);
      CondLe: pass_o = z | (n != v);
      CondAl: pass_o = 1'b1;
      CondNv: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Holds the NZCV flags, latches the per-instruction condition result and gates
// the datapath write enables with it; counts condition-failed instructions.
module cond_flag_unit
  import cfu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  flagw_t           FlagW,
  input  logic             NoRegW,
  input  logic [3:0]       ALUFlags,
  input  logic [3:0]       Cond,
  input  logic             CondLatch,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             PCS,
  input  logic             cnt_clr,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic [CNT_W-1:0] squash_cnt
);

  logic [3:0]       flags_q, flags_d;
  logic             condex_q, condex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass;

  cond_check u_cond_check (
    .cond_i  (Cond),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  // Flag writes are qualified by the CondEx of the instruction in flight,
  // not by the result being latched this cycle.
  always_comb begin
    flags_d = flags_q;
    if (condex_q && FlagW[1]) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (condex_q && FlagW[0]) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  assign condex_d = CondLatch ? pass : condex_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (CondLatch && !pass && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Flags      = flags_q;
  assign CondEx     = condex_q;
  assign RegWrite   = RegW & condex_q & ~NoRegW;
  assign MemWrite   = MemW & condex_q;
  assign PCWrite    = PCS & condex_q;
  assign squash_cnt = cnt_q;

endmodule
